polaris_bus_arbiter: RTL

//  Shares one external memory bus between PolarisCPU's I master (fetch) and D master (load/store).

---
 rtl/polaris_bus_arbiter.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/polaris_bus_arbiter.sv
// Two-master (fetch/data) arbiter for the PolarisCPU memory bus.
// Round-robin on ties, combinational mux and return path, ack watchdog.
module polaris_bus_arbiter #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned TW      = 8
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [63:0] iadr_i,
  input  logic [1:0]  isiz_i,
  output logic [31:0] idat_o,
  output logic        iack_o,
  input  logic        dcyc_i,
  input  logic        dstb_i,
  input  logic        dwe_i,
  input  logic [63:0] dadr_i,
  input  logic [63:0] ddat_i,
  input  logic [1:0]  dsiz_i,
  input  logic        dsigned_i,
  output logic [63:0] ddat_o,
  output logic        dack_o,
  output logic [63:0] madr_o,
  output logic [63:0] mdat_o,
  output logic        mwe_o,
  output logic        mcyc_o,
  output logic        mstb_o,
  output logic [1:0]  msiz_o,
  output logic        msigned_o,
  input  logic [63:0] mdat_i,
  input  logic        mack_i,
  output logic [1:0]  grant_o,
  output logic        timeout_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_IGNT = 2'd1,
    S_DGNT = 2'd2
  } state_t;

  localparam logic [TW-1:0] LP_TMO = TW'(TIMEOUT);

  state_t        r_state;
  state_t        w_next;
  logic          r_last;
  logic          w_last_nxt;
  logic [TW-1:0] r_wdog;
  logic [TW-1:0] w_wdog_nxt;

  logic w_ireq;
  logic w_dreq;
  logic w_ig;
  logic w_dg;
  logic w_busy;
  logic w_greq;
  logic w_expire;

  assign w_ireq   = |isiz_i;
  assign w_dreq   = dcyc_i & dstb_i;
  assign w_ig     = (r_state == S_IGNT);
  assign w_dg     = (r_state == S_DGNT);
  assign w_busy   = w_ig | w_dg;
  assign w_greq   = w_ig ? w_ireq : w_dreq;
  assign w_expire = (TIMEOUT != 0) && w_busy && !mack_i
                    && (r_wdog == LP_TMO);

  // r_last: 1 = data master was served last
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state <= S_IDLE;
      r_last  <= 1'b1;
      r_wdog  <= '0;
    end else begin
      r_state <= w_next;
      r_last  <= w_last_nxt;
      r_wdog  <= w_wdog_nxt;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_last_nxt = r_last;
    w_wdog_nxt = r_wdog;
    unique case (r_state)
      S_IDLE: begin
        w_wdog_nxt = '0;
        if (w_ireq && w_dreq) w_next = r_last ? S_IGNT : S_DGNT;
        else if (w_ireq)      w_next = S_IGNT;
        else if (w_dreq)      w_next = S_DGNT;
      end
      S_IGNT, S_DGNT: begin
        if (mack_i || w_expire) begin
          w_next     = S_IDLE;
          w_last_nxt = w_dg;
          w_wdog_nxt = '0;
        end else if (!w_greq) begin
          w_next     = S_IDLE;
          w_wdog_nxt = '0;
        end else if (r_wdog != LP_TMO) begin
          w_wdog_nxt = r_wdog + 1'b1;
        end
      end
      default: begin
        w_next     = S_IDLE;
        w_wdog_nxt = '0;
      end
    endcase
  end

  always_comb begin
    madr_o    = '0;
    mdat_o    = '0;
    mwe_o     = 1'b0;
    msiz_o    = '0;
    msigned_o = 1'b0;
    unique case (1'b1)
      w_ig: begin
        madr_o = iadr_i;
        msiz_o = isiz_i;
      end
      w_dg: begin
        madr_o    = dadr_i;
        mdat_o    = ddat_i;
        mwe_o     = dwe_i;
        msiz_o    = dsiz_i;
        msigned_o = dsigned_i;
      end
      default: ;
    endcase
  end

  assign mcyc_o    = w_busy;
  assign mstb_o    = w_busy;
  assign grant_o   = {w_dg, w_ig};
  assign timeout_o = w_expire;
  assign iack_o    = w_ig & (mack_i | w_expire);
  assign dack_o    = w_dg & (mack_i | w_expire);
  assign idat_o    = (w_ig & mack_i) ? mdat_i[31:0] : '0;
  assign ddat_o    = (w_dg & mack_i) ? mdat_i : '0;

endmodule
